// File: rtl/rf_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds state encodings, mux-select meanings and default widths.
package rf_wr_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STARVE_W   = 3;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_e;

  localparam logic WSEL_ALU = 1'b0;
  localparam logic WSEL_MEM = 1'b1;

  // Saturating increment used by the ALU starvation counter.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] max);
    return (v >= max) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rf_mux2.sv
// Two-input mux of parameterised width; sel=0 picks side A, sel=1 picks side B.
module rf_mux2 #(
  parameter int unsigned W = 5
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/rf_wr_reg.sv
// One-stage write register feeding the register file.
// Writes to R0 are captured but never raise the write enable.
module rf_wr_reg #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (accept) begin
      we_d   = (addr != '0);
      addr_d = addr;
      data_d = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = addr_q;
  assign rf_wdata = data_q;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the register file's single write port between the ALU and load paths.
// Memory has fixed priority; a starvation counter eventually hands priority to the ALU.
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              wsel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        starve_cnt
);

  localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                wsel_q;
  logic                alu_gnt, mem_gnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Grants are masked while reset is asserted so nothing is accepted during reset.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        PRI_MEM: begin
          if (mem_valid)      mem_gnt = 1'b1;
          else if (alu_valid) alu_gnt = 1'b1;
        end
        PRI_ALU: begin
          if (alu_valid)      alu_gnt = 1'b1;
          else if (mem_valid) mem_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wsel = wsel_q;
    if (alu_gnt)      wsel = WSEL_ALU;
    else if (mem_gnt) wsel = WSEL_MEM;
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (alu_gnt) begin
      starve_d = '0;
    end else if (mem_gnt && alu_valid) begin
      starve_d = sat_inc(starve_q, StarveMax);
    end
    unique case (state_q)
      PRI_MEM: if (starve_d == StarveMax) state_d = PRI_ALU;
      PRI_ALU: if (alu_gnt)               state_d = PRI_MEM;
      default: state_d = PRI_MEM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PRI_MEM;
      starve_q <= '0;
      wsel_q   <= WSEL_ALU;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wsel_q   <= wsel;
    end
  end

  assign starve_cnt = starve_q;

  rf_mux2 #(
    .W(ADDR_W)
  ) u_addr_mux (
    .sel(wsel),
    .a  (alu_addr),
    .b  (mem_addr),
    .y  (sel_addr)
  );

  rf_mux2 #(
    .W(DATA_W)
  ) u_data_mux (
    .sel(wsel),
    .a  (alu_data),
    .b  (mem_data),
    .y  (sel_data)
  );

  rf_wr_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (alu_gnt | mem_gnt),
    .addr    (sel_addr),
    .data    (sel_data),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );

endmodule
